// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout buffer: FIFO entry layout,
// pixel width and the readout event classification.
package pixel_readout_pkg;

    localparam int PIX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             first;
        logic             last;
    } pix_entry_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_P12,
        EV_P34
    } ev_t;

    // Build a FIFO entry from a pixel byte and its frame markers.
    function automatic pix_entry_t mk_entry(
        input logic [PIX_W-1:0] d,
        input logic             f,
        input logic             l
    );
        pix_entry_t e;
        e.data  = d;
        e.first = f;
        e.last  = l;
        return e;
    endfunction

endpackage

// File: rtl/pixel_fifo_2w1r.sv
// Two-write / one-read FIFO of pixel entries. A push always writes
// two entries in order; the caller guarantees room for both.
module pixel_fifo_2w1r
    import pixel_readout_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  pix_entry_t                 i_e0,
    input  pix_entry_t                 i_e1,
    input  logic                       i_pop,
    output pix_entry_t                 o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    pix_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_wr_ptr1;
    logic [AW-1:0] w_wr_ptr2;
    logic [AW-1:0] w_rd_ptr1;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // Advance a pointer by n, wrapping modulo DEPTH (DEPTH need not be 2^k).
    function automatic logic [AW-1:0] f_adv(
        input logic [AW-1:0] p,
        input logic [1:0]    n
    );
        logic [CW-1:0] s;
        s = {1'b0, p} + {{(CW-2){1'b0}}, n};
        if (s >= LP_DEPTH) begin
            s = s - LP_DEPTH;
        end
        return s[AW-1:0];
    endfunction

    assign w_wr_ptr1 = f_adv(r_wr_ptr, 2'd1);
    assign w_wr_ptr2 = f_adv(r_wr_ptr, 2'd2);
    assign w_rd_ptr1 = f_adv(r_rd_ptr, 2'd1);
    assign w_pop     = i_pop & (r_count != '0);

    // Next occupancy: +2 per push, -1 per pop, both may coincide.
    always_comb begin
        w_count_nxt = r_count;
        if (i_push) begin
            w_count_nxt = w_count_nxt + CW'(2);
        end
        if (w_pop) begin
            w_count_nxt = w_count_nxt - CW'(1);
        end
    end

    // Storage write: both entries of a pair land in the same cycle.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr]  <= i_e0;
            r_mem[w_wr_ptr1] <= i_e1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= w_wr_ptr2;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr1;
            end
            r_count <= w_count_nxt;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_free  = LP_DEPTH - r_count;

endmodule

// File: rtl/pixel_readout_buffer.sv
// Captures pixel pairs on the falling edge of each read phase and
// streams them out as bytes with frame markers and drop accounting.
module pixel_readout_buffer
    import pixel_readout_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read12,
    input  logic               read34,
    input  logic [PIX_W-1:0]   pixelDataOut1,
    input  logic [PIX_W-1:0]   pixelDataOut2,
    input  logic [PIX_W-1:0]   pixelDataOut3,
    input  logic [PIX_W-1:0]   pixelDataOut4,
    output logic [PIX_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_first,
    output logic               out_last,
    output logic [FRAME_W-1:0] frame_count,
    output logic [7:0]         drop_count,
    output logic               overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               r_read12_q;
    logic               r_read34_q;
    logic [FRAME_W-1:0] r_frame_count;
    logic [7:0]         r_drop_count;
    logic               r_overflow;
    logic               r_drop_frame;

    logic          w_fall12;
    logic          w_fall34;
    ev_t           w_ev;
    logic          w_room;
    logic          w_push;
    logic          w_pop;
    pix_entry_t    w_e0;
    pix_entry_t    w_e1;
    pix_entry_t    w_head;
    logic          w_valid;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic [1:0]    w_ndrop;
    logic          w_df_nxt;
    logic          w_frame_inc;
    logic [8:0]    w_drop_sum;

    assign w_fall12 = r_read12_q & ~read12;
    assign w_fall34 = r_read34_q & ~read34;
    assign w_ev     = w_fall12 ? EV_P12 :
                      w_fall34 ? EV_P34 : EV_NONE;
    assign w_room   = (w_free >= CW'(2));
    assign w_pop    = w_valid & out_ready;

    // Classify the readout event and decide push / drop / frame tracking.
    always_comb begin
        w_push      = 1'b0;
        w_e0        = '0;
        w_e1        = '0;
        w_ndrop     = 2'd0;
        w_df_nxt    = r_drop_frame;
        w_frame_inc = 1'b0;
        case (w_ev)
            EV_P12: begin
                w_e0 = mk_entry(pixelDataOut1, 1'b1, 1'b0);
                w_e1 = mk_entry(pixelDataOut2, 1'b0, 1'b0);
                if (w_room) begin
                    w_push = 1'b1;
                end else begin
                    w_ndrop  = 2'd1;
                    w_df_nxt = 1'b1;
                end
                if (w_fall34) begin
                    w_ndrop = w_ndrop + 2'd1;
                end
            end
            EV_P34: begin
                w_e0     = mk_entry(pixelDataOut3, 1'b0, 1'b0);
                w_e1     = mk_entry(pixelDataOut4, 1'b0, 1'b1);
                w_df_nxt = 1'b0;
                if (r_drop_frame || !w_room) begin
                    w_ndrop = 2'd1;
                end else begin
                    w_push      = 1'b1;
                    w_frame_inc = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_ndrop};

    // Edge-detect registers, counters and sticky drop state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_read12_q    <= 1'b0;
            r_read34_q    <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
            r_drop_frame  <= 1'b0;
        end else begin
            r_read12_q   <= read12;
            r_read34_q   <= read34;
            r_drop_frame <= w_df_nxt;
            if (w_frame_inc) begin
                r_frame_count <= r_frame_count + FRAME_W'(1);
            end
            if (w_ndrop != 2'd0) begin
                r_overflow   <= 1'b1;
                r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            end
        end
    end

    pixel_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_e0    (w_e0),
        .i_e1    (w_e1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count),
        .o_free  (w_free)
    );

    assign out_valid   = w_valid;
    assign out_data    = w_valid ? w_head.data  : '0;
    assign out_first   = w_valid ? w_head.first : 1'b0;
    assign out_last    = w_valid ? w_head.last  : 1'b0;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: framing, overflow drops,
// simultaneous push/pop, reset mid-frame and coincident read edges.
module tb_pixel_readout_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read12 = 1'b0;
    logic        read34 = 1'b0;
    logic [7:0]  p1 = '0;
    logic [7:0]  p2 = '0;
    logic [7:0]  p3 = '0;
    logic [7:0]  p4 = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_first;
    logic        out_last;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;
    logic        overflow;

    int n_asserts = 0;
    int n_fail = 0;

    pixel_readout_buffer #(
        .DEPTH   (16),
        .FRAME_W (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read12        (read12),
        .read34        (read34),
        .pixelDataOut1 (p1),
        .pixelDataOut2 (p2),
        .pixelDataOut3 (p3),
        .pixelDataOut4 (p4),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_last      (out_last),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        read12 = 1'b0;
        read34 = 1'b0;
        reset  = 1'b0;
        step();
        reset  = 1'b1;
    endtask

    task automatic pair12(input logic [7:0] a, input logic [7:0] b);
        p1 = a;
        p2 = b;
        read12 = 1'b1;
        step();
        read12 = 1'b0;
        step();
    endtask

    task automatic pair34(input logic [7:0] c, input logic [7:0] d);
        p3 = c;
        p4 = d;
        read34 = 1'b1;
        step();
        read34 = 1'b0;
        step();
    endtask

    task automatic frame(input logic [7:0] base);
        pair12(base + 8'd1, base + 8'd2);
        pair34(base + 8'd3, base + 8'd4);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        // Reset state
        reset = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_frames", frame_count, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;

        // Single frame, consumer always ready
        out_ready = 1'b1;
        p1 = 8'h11; p2 = 8'h22; p3 = 8'h33; p4 = 8'h44;
        read12 = 1'b1;
        step();
        read12 = 1'b0;
        step();
        chk("t1_v0", out_valid, 1);
        chk("t1_b0", out_data, 8'h11);
        chk("t1_f0", out_first, 1);
        read34 = 1'b1;
        step();
        chk("t1_b1", out_data, 8'h22);
        chk("t1_f1", {out_first, out_last}, 0);
        read34 = 1'b0;
        step();
        chk("t1_b2", out_data, 8'h33);
        chk("t1_v2", out_valid, 1);
        step();
        chk("t1_b3", out_data, 8'h44);
        chk("t1_l3", out_last, 1);
        chk("t1_frames", frame_count, 1);
        step();
        chk("t1_empty", out_valid, 0);
        chk("t1_drops", drop_count, 0);

        // Fill with 4 frames, 5th frame dropped whole
        do_reset();
        out_ready = 1'b0;
        frame(8'h10);
        frame(8'h20);
        frame(8'h30);
        frame(8'h40);
        chk("t2_count16", dut.w_count, 16);
        chk("t2_head", out_data, 8'h11);
        pair12(8'h51, 8'h52);
        chk("t2_drop1", drop_count, 1);
        chk("t2_ovf", overflow, 1);
        pair34(8'h53, 8'h54);
        chk("t2_drop2", drop_count, 2);
        chk("t2_frames", frame_count, 4);
        chk("t2_count_kept", dut.w_count, 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'((i / 4 + 1) * 16 + (i % 4) + 1);
            chk("t2_drain_v", out_valid, 1);
            chk("t2_drain_d", out_data, exp_b);
            chk("t2_drain_fl", {out_first, out_last},
                {30'd0, (i % 4) == 0, (i % 4) == 3});
            step();
        end
        out_ready = 1'b0;
        chk("t2_drained", out_valid, 0);

        // count=15 with a falling read12
        do_reset();
        frame(8'h10);
        frame(8'h20);
        frame(8'h30);
        frame(8'h40);
        pop_one();
        chk("t3_count15", dut.w_count, 15);
        pair12(8'h91, 8'h92);
        chk("t3_drop12", drop_count, 1);
        chk("t3_count_hold", dut.w_count, 15);
        pair34(8'h93, 8'h94);
        chk("t3_drop34", drop_count, 2);
        chk("t3_frames", frame_count, 4);
        pop_one();
        chk("t3_count14", dut.w_count, 14);
        pair12(8'hA1, 8'hA2);
        chk("t3_accept", dut.w_count, 16);
        chk("t3_drop_same", drop_count, 2);

        // Simultaneous push and pop at count=5
        do_reset();
        frame(8'h60);
        pair12(8'h71, 8'h72);
        pop_one();
        chk("t4_count5", dut.w_count, 5);
        chk("t4_head5", out_data, 8'h62);
        p3 = 8'h73;
        p4 = 8'h74;
        read34 = 1'b1;
        step();
        read34 = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_count6", dut.w_count, 6);
        chk("t4_head6", out_data, 8'h63);

        // Reset with count=7 and read34 high
        do_reset();
        frame(8'h10);
        frame(8'h20);
        pop_one();
        chk("t5_count7", dut.w_count, 7);
        read34 = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t5_rst_v", out_valid, 0);
        chk("t5_rst_d", out_data, 0);
        chk("t5_rst_fl", {out_first, out_last}, 0);
        chk("t5_rst_cnt", {frame_count, drop_count, 7'd0, overflow}, 0);
        reset = 1'b1;
        step();
        chk("t5_no_event", out_valid, 0);
        p3 = 8'h5A;
        p4 = 8'hA5;
        read34 = 1'b0;
        step();
        chk("t5_v", out_valid, 1);
        chk("t5_b0", out_data, 8'h5A);
        chk("t5_fl0", {out_first, out_last}, 0);
        chk("t5_frames", frame_count, 1);
        out_ready = 1'b1;
        step();
        chk("t5_b1", out_data, 8'hA5);
        chk("t5_l1", out_last, 1);
        step();
        out_ready = 1'b0;
        chk("t5_empty", out_valid, 0);

        // Coincident fall12 and fall34
        do_reset();
        p1 = 8'h81; p2 = 8'h82; p3 = 8'h83; p4 = 8'h84;
        read12 = 1'b1;
        read34 = 1'b1;
        step();
        read12 = 1'b0;
        read34 = 1'b0;
        step();
        chk("t6_count2", dut.w_count, 2);
        chk("t6_head", out_data, 8'h81);
        chk("t6_first", out_first, 1);
        chk("t6_drops", drop_count, 1);
        chk("t6_ovf", overflow, 1);
        chk("t6_frames", frame_count, 0);
        out_ready = 1'b1;
        step();
        chk("t6_b1", out_data, 8'h82);
        step();
        chk("t6_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_readout_buffer.md
# pixel_readout_buffer

Downstream stage of the pixel-array state machine. Captures the four 8-bit pixel values the array presents during its READ12 and READ34 phases and queues them in a small FIFO. Emits them as a byte stream with valid/ready handshake and frame markers. Sits between the pixel-array controller and the off-chip/serial link logic, decoupling the fixed-rate readout phases from a back-pressured consumer.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (bytes). Must be even and ≥ 4.
- FRAME_W, 16, width of the frame counter.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-low reset
- read12  input  1  pixel pair 1/2 read phase from upstream
- read34  input  1  pixel pair 3/4 read phase from upstream
- pixelDataOut1..4  input  8 each  pixel values from upstream, stable once the matching read phase ends
- out_data  output  8  pixel byte at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts byte when out_valid & out_ready
- out_first  output  1  head byte is pixel 1 of a frame
- out_last  output  1  head byte is pixel 4 of a frame
- frame_count  output  FRAME_W  complete frames accepted, wraps
- drop_count  output  8  pairs dropped, saturates at 255
- overflow  output  1  sticky: at least one pair dropped since reset

## Operation
- Registered copies read12_q and read34_q are reset to 0. The falling-edge events are fall12 = read12_q & ~read12 and fall34 = read34_q & ~read34.
- On fall12, push pair {pixelDataOut1 (first=1), pixelDataOut2}. On fall34, push pair {pixelDataOut3, pixelDataOut4 (last=1)}.
- A pair is written atomically as two entries in one cycle, in order, or it is not written at all.
- Free space is DEPTH − count, using registered count. A pop in the same cycle is not credited to that push.
- A push with free < 2 is dropped. The block sets overflow, increments drop_count (saturating) and sets drop_frame.
- On fall34, if drop_frame is set, pair 3/4 is also dropped (counted). drop_frame then clears. The consumer never sees a partial frame.
- frame_count increments on every accepted 3/4 pair.
- If fall12 and fall34 occur in the same cycle, 1/2 takes priority. 3/4 is dropped and counted.
- Pop occurs when out_valid & out_ready. Simultaneous push and pop are legal, and count updates by +2−1.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.

## Timing
- Reset (reset=0 at a rising edge) forces: count=0, pointers=0, out_valid=0, out_first=0, out_last=0, out_data=0, frame_count=0, drop_count=0, overflow=0, drop_frame=0, read12_q=0, read34_q=0.
- Reset mid-frame discards FIFO contents. A read phase still high when reset releases produces no event until its falling edge. That pair is accepted normally.
- Latency: a pair pushed at edge N into an empty FIFO gives out_valid=1 with pixel 1 on out_data after edge N.
- out_data, out_first and out_last are valid whenever out_valid=1. They are stable while out_valid & ~out_ready.
- Throughput: the consumer may pop one byte per cycle, continuously.
- out_valid depends only on registered state, with no combinational path from out_ready.

## Structure
- Package pixel_readout_pkg:
  - typedef pix_entry_t {logic [7:0] data; logic first; logic last;}
  - PIX_W=8
  - event-type enum {EV_NONE, EV_P12, EV_P34}
- Sub-module pixel_fifo_2w1r: a parameterised 2-write/1-read FIFO of pix_entry_t, with count and free outputs.
- The top level holds edge detection, the drop/frame logic and the counters.

## Test plan
- Single frame, out_ready=1, pixels 0x11/0x22/0x33/0x44:
  - bytes 11,22,33,44 emitted in order
  - first on 11, last on 44
  - frame_count=1, drop_count=0
- out_ready=0, DEPTH=16, 4 frames followed by a 5th frame:
  - frames 1–4 fill the FIFO (count=16)
  - frame 5 pair 1/2 dropped, then pair 3/4 dropped
  - drop_count=2, overflow=1, frame_count=4
  - draining yields exactly 16 bytes of 4 whole frames
- FIFO at count=15, fall12 occurs:
  - pair dropped
  - after pops reach count≤14, the next frame's 1/2 pair is accepted
- Simultaneous push and pop at count=5 → count=6 next cycle, head byte advances correctly.
- Reset asserted with count=7 and read34 high:
  - all outputs 0 next cycle
  - the subsequent fall of read34 pushes one 3/4 pair (last on second byte)
  - frame_count=1
- Forced fall12 & fall34 in the same cycle → only the 1/2 pair written, drop_count=1.
